// File: rtl/run_ctrl_pkg.sv
// Shared types and default parameter values for the run controller.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HOLD = 3'd1,
        ST_RUN  = 3'd2,
        ST_HALT = 3'd3,
        ST_TMO  = 3'd4
    } state_t;

    localparam int DEF_CNT_W        = 32;
    localparam int DEF_PC_W         = 32;
    localparam int DEF_RESET_CYCLES = 2;
    localparam int DEF_MAX_CYCLES   = 750;
    localparam int DEF_HALT_REPEAT  = 3;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/run_controller.sv
// Sequences a core through reset/run and stops it on a pc self-loop or a cycle budget.
// Define RUN_CTRL_INSTR_CNT_EN to build the retired-instruction counter; otherwise instr_count reads 0.
//   state | meaning
//   IDLE  | core held in reset, waiting for start
//   HOLD  | core reset held for RESET_CYCLES after start
//   RUN   | core executing, counters and halt detector active
//   HALT  | finished: pc repeated HALT_REPEAT times
//   TMO   | finished: cycle budget exhausted
module run_controller
    import run_ctrl_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int PC_W         = DEF_PC_W,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
    parameter int HALT_REPEAT  = DEF_HALT_REPEAT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  pc,
    input  logic             pc_valid,
    output logic             core_reset,
    output logic             running,
    output logic             done,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam int REP_W  = $clog2(HALT_REPEAT + 1);

    state_t             state;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [REP_W-1:0]   rep_cnt;
    logic [REP_W-1:0]   rep_next;
    logic [PC_W-1:0]    last_pc;
    logic               start_accept;
    logic               in_run;
    logic               hold_last;
    logic               halt_hit;
    logic               tmo_hit;

    always_comb begin
        start_accept = start && ((state == ST_IDLE) || (state == ST_HALT) || (state == ST_TMO));
        in_run       = (state == ST_RUN);
        hold_last    = (state == ST_HOLD) && (hold_cnt == HOLD_W'(RESET_CYCLES - 1));
        // A zero repeat count means no valid pc seen yet in this run.
        if ((rep_cnt != '0) && (pc == last_pc)) begin
            rep_next = rep_cnt + REP_W'(1);
        end else begin
            rep_next = REP_W'(1);
        end
        halt_hit = in_run && pc_valid && (rep_next == REP_W'(HALT_REPEAT));
        tmo_hit  = in_run && (cycle_count != '1) &&
                   ((cycle_count + CNT_W'(1)) == CNT_W'(MAX_CYCLES));
    end

    sat_counter #(.W(HOLD_W)) u_hold_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (start_accept),
        .enable (state == ST_HOLD),
        .count  (hold_cnt)
    );

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (start_accept),
        .enable (in_run),
        .count  (cycle_count)
    );

`ifdef RUN_CTRL_INSTR_CNT_EN
    sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (start_accept),
        .enable (in_run && pc_valid),
        .count  (instr_count)
    );
`else
    assign instr_count = '0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            core_reset <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b0;
            halted     <= 1'b0;
            timeout    <= 1'b0;
            rep_cnt    <= '0;
            last_pc    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT, ST_TMO: begin
                    if (start) begin
                        state      <= ST_HOLD;
                        core_reset <= 1'b1;
                        running    <= 1'b0;
                        done       <= 1'b0;
                        halted     <= 1'b0;
                        timeout    <= 1'b0;
                        rep_cnt    <= '0;
                        last_pc    <= '0;
                    end
                end
                ST_HOLD: begin
                    if (hold_last) begin
                        state      <= ST_RUN;
                        core_reset <= 1'b0;
                        running    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (pc_valid) begin
                        rep_cnt <= rep_next;
                        last_pc <= pc;
                    end
                    // Halt takes priority when both finish causes land together.
                    if (halt_hit) begin
                        state      <= ST_HALT;
                        core_reset <= 1'b1;
                        running    <= 1'b0;
                        done       <= 1'b1;
                        halted     <= 1'b1;
                    end else if (tmo_hit) begin
                        state      <= ST_TMO;
                        core_reset <= 1'b1;
                        running    <= 1'b0;
                        done       <= 1'b1;
                        timeout    <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    core_reset <= 1'b1;
                    running    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/run_controller.md
RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL expose these parameters:
- CNT_W, 32, width of cycle and instruction counters.
- PC_W, 32, width of the monitored program counter.
- RESET_CYCLES, 2, cycles core_reset is held after start; legal range >= 1.
- MAX_CYCLES, 750, RUN-cycle budget before timeout; legal range >= 1.
- HALT_REPEAT, 3, consecutive identical valid pc samples that mean "halted"; legal range >= 2.

REQ-003 The block SHALL have these ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low block reset.
- start  in  1  one-cycle request to (re)run the core.
- pc  in  PC_W  core program counter.
- pc_valid  in  1  core retired an instruction at pc this cycle.
- core_reset  out  1  active-high reset to the core.
- running  out  1  core is executing.
- done  out  1  run finished; sticky until next start.
- halted  out  1  finished by self-loop detection.
- timeout  out  1  finished by cycle budget.
- cycle_count  out  CNT_W  RUN cycles elapsed.
- instr_count  out  CNT_W  valid instructions retired in RUN.

Function
REQ-004 The block SHALL implement FSM states IDLE, HOLD, RUN, HALT and TMO, with all outputs registered.
REQ-005 In IDLE, core_reset SHALL be 1; start moves the FSM to HOLD next cycle, clears both counters, the repeat count and all flags.
REQ-006 HOLD SHALL last exactly RESET_CYCLES cycles with core_reset=1, then move to RUN; if start at cycle t, running=1 and core_reset=0 from cycle t+1+RESET_CYCLES.
REQ-007 In RUN, cycle_count SHALL increment by 1 every cycle, saturating at 2^CNT_W-1.
REQ-008 In RUN, instr_count SHALL increment when pc_valid=1, saturating at 2^CNT_W-1.
REQ-009 Halt detection:
- On pc_valid with pc equal to the last valid pc, the repeat count increments; otherwise it loads 1.
- When the repeat count reaches HALT_REPEAT, the FSM moves to HALT.
- The first valid sample after HOLD always loads 1.
REQ-010 When the increment makes cycle_count equal MAX_CYCLES, the FSM SHALL move to TMO.
REQ-011 If halt and timeout conditions occur in the same cycle, HALT SHALL win: halted=1, timeout=0.
REQ-012 In HALT and TMO:
- done=1, running=0, core_reset=1.
- Counters are frozen.
- halted/timeout are set according to the finishing cause.
REQ-013 start SHALL be ignored in HOLD and RUN; in HALT or TMO, start behaves as in IDLE (rerun).
REQ-014 pc_valid outside RUN SHALL be ignored.

Reset
REQ-015 While reset=0, the FSM SHALL be in IDLE with:
- core_reset=1.
- running=0, done=0, halted=0, timeout=0.
- cycle_count=0, instr_count=0, repeat count=0, last pc=0.
REQ-016 Reset assertion mid-HOLD or mid-RUN SHALL take effect immediately, without waiting for a clock edge; after deassertion the FSM stays in IDLE until start.

Configuration
REQ-017 With macro RUN_CTRL_INSTR_CNT_EN defined, instr_count SHALL behave per REQ-008.
REQ-018 Without RUN_CTRL_INSTR_CNT_EN, the following SHALL hold:
- instr_count is constant 0 and its counter is not built.
- pc_valid still drives halt detection.

Structure
REQ-019 Package run_ctrl_pkg SHALL hold:
- the FSM state enum;
- default parameter constants.
REQ-020 The saturating counter SHALL be one sub-module, sat_counter, with enable, synchronous clear and width parameter, instantiated for cycle_count, instr_count and the HOLD counter.

Verification
REQ-021 The bench SHALL cover these scenarios (default parameters unless noted):
- Reset 0 for 3 cycles, start at cycle 5 -> core_reset=1 through cycle 7; running=1, core_reset=0 from cycle 8.
- In RUN, pc_valid every cycle with pc 0x0,0x4,0x8,0x8,0x8 -> halted=1, done=1 on the cycle after the third 0x8; instr_count=5; cycle_count=5.
- pc_valid with pc never repeating -> timeout=1, halted=0, cycle_count=750.
- MAX_CYCLES=5, pc 0x10 valid on RUN cycles 3,4,5 -> halted=1, timeout=0.
- reset=0 asserted on RUN cycle 100 -> all outputs take reset values before the next clock edge; start after release reruns from zero.
- start in HALT -> done/halted cleared, counts 0, HOLD for 2 cycles, then RUN; start pulses during RUN have no effect.
